// File: rtl/gcd_stein.sv
// gcd_stein: iterative binary (Stein) GCD engine with a start / valid / out_ready
// handshake. One reduction step is taken per clock while busy.
// Optional cycle counter output `cycles` is compiled in when the macro
// GCD_STEIN_CYCLE_CNT_EN is defined; without it the port and counter are absent.
module gcd_stein #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             out_ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] out
`ifdef GCD_STEIN_CYCLE_CNT_EN
    ,
    output logic [$clog2(2*WIDTH+2)-1:0] cycles
`endif
);

    // k counts common factors of two; it never exceeds WIDTH-1 for nonzero operands
    localparam int K_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [K_W-1:0]   k_reg, k_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic             valid_reg, valid_next;

    // Register update; reset wins over any in-flight computation or handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            k_reg     <= '0;
            out_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            k_reg     <= k_next;
            out_reg   <= out_next;
            valid_reg <= valid_next;
        end
    end

    // Next-state and datapath: one Stein step per BUSY cycle, first matching case wins
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        k_next     = k_reg;
        out_next   = out_reg;
        valid_next = valid_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = a_in;
                    b_next     = b_in;
                    k_next     = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (a_reg == '0) begin
                    out_next   = b_reg << k_reg;
                    valid_next = 1'b1;
                    state_next = DONE;
                end else if (b_reg == '0) begin
                    out_next   = a_reg << k_reg;
                    valid_next = 1'b1;
                    state_next = DONE;
                end else if (!a_reg[0] && !b_reg[0]) begin
                    a_next = a_reg >> 1;
                    b_next = b_reg >> 1;
                    k_next = k_reg + K_W'(1);
                end else if (!a_reg[0]) begin
                    a_next = a_reg >> 1;
                end else if (!b_reg[0]) begin
                    b_next = b_reg >> 1;
                end else if (a_reg >= b_reg) begin
                    // both odd: the difference is even, so halve it in the same step
                    a_next = (a_reg - b_reg) >> 1;
                end else begin
                    b_next = (b_reg - a_reg) >> 1;
                end
            end
            DONE: begin
                // start is deliberately not looked at here, even on the handshake edge
                if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = (state_reg != IDLE);
    assign valid = valid_reg;
    assign out   = out_reg;

`ifdef GCD_STEIN_CYCLE_CNT_EN
    localparam int CNT_W = $clog2(2*WIDTH+2);

    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Cycle counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Clear on accepted start, count every BUSY edge (saturating), hold otherwise
    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == IDLE && start) begin
            cnt_next = '0;
        end else if (state_reg == BUSY && cnt_reg != {CNT_W{1'b1}}) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    assign cycles = cnt_reg;
`endif

endmodule

// File: tb/tb_gcd_stein.sv
// tb_gcd_stein: self-checking bench for gcd_stein. Two instances (WIDTH=16 and
// WIDTH=8) are exercised with directed and random operands and compared against
// a Euclid-based reference gcd. Cycle-count checks are active when
// GCD_STEIN_CYCLE_CNT_EN is defined.
module tb_gcd_stein;

    logic        clk = 1'b0;
    logic        rst;

    logic        start16, ready16, busy16, valid16;
    logic [15:0] a16, b16, out16;
    logic        start8, ready8, busy8, valid8;
    logic [7:0]  a8, b8, out8;

`ifdef GCD_STEIN_CYCLE_CNT_EN
    logic [$clog2(34)-1:0] cyc16;
    logic [$clog2(18)-1:0] cyc8;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gcd_stein #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .start     (start16),
        .a_in      (a16),
        .b_in      (b16),
        .out_ready (ready16),
        .busy      (busy16),
        .valid     (valid16),
        .out       (out16)
`ifdef GCD_STEIN_CYCLE_CNT_EN
        ,
        .cycles    (cyc16)
`endif
    );

    gcd_stein #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .a_in      (a8),
        .b_in      (b8),
        .out_ready (ready8),
        .busy      (busy8),
        .valid     (valid8),
        .out       (out8)
`ifdef GCD_STEIN_CYCLE_CNT_EN
        ,
        .cycles    (cyc8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: Euclid's algorithm on plain integers
    function automatic longint unsigned ref_gcd(input longint unsigned x, input longint unsigned y);
        longint unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic cur_busy(input bit w8);
        return w8 ? busy8 : busy16;
    endfunction

    function automatic logic cur_valid(input bit w8);
        return w8 ? valid8 : valid16;
    endfunction

    function automatic logic [15:0] cur_out(input bit w8);
        return w8 ? {8'h00, out8} : out16;
    endfunction

`ifdef GCD_STEIN_CYCLE_CNT_EN
    function automatic int cur_cycles(input bit w8);
        return w8 ? int'(cyc8) : int'(cyc16);
    endfunction
`endif

    // Called just after a falling edge with the DUT idle; returns just after a falling edge.
    task automatic do_op(input bit w8, input logic [15:0] a, input logic [15:0] b, input bit rdy,
                         output logic [15:0] res, output int ncyc);
        bit done;
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; ready8 = rdy;
        end else begin
            a16 = a; b16 = b; start16 = 1'b1; ready16 = rdy;
        end
        @(posedge clk);
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
        check("accept_busy", cur_busy(w8), 1'b1);
        ncyc = 0;
        done = 1'b0;
        while (!done && ncyc < 200) begin
            @(posedge clk);
            ncyc++;
            @(negedge clk);
            if (cur_valid(w8)) done = 1'b1;
        end
        if (!done) check("timeout_valid", cur_valid(w8), 1'b1);
        res = cur_out(w8);
`ifdef GCD_STEIN_CYCLE_CNT_EN
        check("cycles", cur_cycles(w8), ncyc);
`endif
        $display("[TB] w=%0d a=%0h b=%0h out=%0h busy_cycles=%0d", w8 ? 8 : 16, a, b, res, ncyc);
        if (rdy && done) begin
            @(posedge clk);
            @(negedge clk);
            check("handshake_valid", cur_valid(w8), 1'b0);
            check("handshake_busy", cur_busy(w8), 1'b0);
        end
    endtask

    logic [15:0] res;
    int          ncyc;
    logic [15:0] ra, rb;
    int          waited;

    initial begin
        rst = 1'b1;
        start16 = 1'b0; ready16 = 1'b0; a16 = '0; b16 = '0;
        start8  = 1'b0; ready8  = 1'b0; a8  = '0; b8  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy16", busy16, 1'b0);
        check("rst_valid16", valid16, 1'b0);
        check("rst_out16", out16, 16'h0);
        check("rst_busy8", busy8, 1'b0);
        check("rst_out8", out8, 8'h0);
`ifdef GCD_STEIN_CYCLE_CNT_EN
        check("rst_cycles16", cyc16, 0);
`endif
        rst = 1'b0;

        // Basic GCD, seven BUSY edges
        do_op(1'b0, 16'd48, 16'd18, 1'b1, res, ncyc);
        check("basic_out", res, 16'd6);
        check("basic_latency", ncyc, 7);

        // Zero operands
        do_op(1'b0, 16'd0, 16'd0, 1'b1, res, ncyc);
        check("zero00_out", res, 16'd0);
        check("zero00_latency", ncyc, 1);
        do_op(1'b0, 16'd0, 16'd35, 1'b1, res, ncyc);
        check("zero0b_out", res, 16'd35);
        do_op(1'b0, 16'd40, 16'd0, 1'b1, res, ncyc);
        check("zeroa0_out", res, 16'd40);

        // Backpressure with a stray start during DONE
        do_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, res, ncyc);
        check("bp_out", res, 16'hFFFF);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                a16 = 16'd6; b16 = 16'd4; start16 = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            start16 = 1'b0;
            check("bp_hold_valid", valid16, 1'b1);
            check("bp_hold_out", out16, 16'hFFFF);
        end
        ready16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_busy", busy16, 1'b0);
        check("bp_release_valid", valid16, 1'b0);
        check("bp_retain_out", out16, 16'hFFFF);
        @(posedge clk);
        @(negedge clk);
        check("bp_no_pending_start", busy16, 1'b0);

        // Reset on the fifth BUSY edge
        a16 = 16'h8000; b16 = 16'h7FFF; start16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midrst_still_busy", busy16, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", busy16, 1'b0);
        check("midrst_valid", valid16, 1'b0);
        check("midrst_out", out16, 16'h0);
`ifdef GCD_STEIN_CYCLE_CNT_EN
        check("midrst_cycles", cyc16, 0);
`endif
        rst = 1'b0;
        do_op(1'b0, 16'd12, 16'd8, 1'b1, res, ncyc);
        check("after_rst_out", res, 16'd4);

        // Back-to-back: start held high, restart only one edge after each handshake
        a16 = 16'd12; b16 = 16'd18; ready16 = 1'b1; start16 = 1'b1;
        for (int it = 0; it < 3; it++) begin
            waited = 0;
            do begin
                @(posedge clk);
                @(negedge clk);
                waited++;
            end while (!valid16 && waited < 100);
            check("b2b_valid", valid16, 1'b1);
            check("b2b_out", out16, 16'd6);
            @(posedge clk);
            @(negedge clk);
            check("b2b_idle_busy", busy16, 1'b0);
            check("b2b_idle_valid", valid16, 1'b0);
            @(posedge clk);
            @(negedge clk);
            check("b2b_restart_busy", busy16, 1'b1);
            $display("[TB] b2b iteration %0d out=%0h", it, out16);
        end
        start16 = 1'b0;
        waited = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end while (busy16 && waited < 100);
        check("b2b_drain_busy", busy16, 1'b0);

        // WIDTH=8 corners and random sweep
        do_op(1'b1, 16'd255, 16'd255, 1'b1, res, ncyc);
        check("w8_255_255", res, ref_gcd(255, 255));
        do_op(1'b1, 16'd1, 16'd255, 1'b1, res, ncyc);
        check("w8_1_255", res, ref_gcd(1, 255));
        do_op(1'b1, 16'd128, 16'd64, 1'b1, res, ncyc);
        check("w8_128_64", res, ref_gcd(128, 64));
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            do_op(1'b1, ra, rb, 1'b1, res, ncyc);
            check("w8_rand_out", res, ref_gcd(ra, rb));
            check("w8_cycle_bound", ncyc <= 17, 1'b1);
        end

        // WIDTH=16 random pairs
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            do_op(1'b0, ra, rb, 1'b1, res, ncyc);
            check("w16_rand_out", res, ref_gcd(ra, rb));
            check("w16_cycle_bound", ncyc <= 33, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
